regfile_port_arbiter: RTL

- Round-robin scheduler sharing the eight-register, 16-bit register file between NREQ requesters.
- Each access is a single read or a single write.
- Drives the 3-bit select of the 16-bit 8-to-1 read mux and the one-hot register load enables.
- Captures the mux output into a registered read-return channel tagged with the requester ID.

---
 rtl/regfile_port_arbiter_if.sv | 20 ++
 rtl/regfile_port_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter: request/grant handshake
// plus the tagged read-return channel.
interface regfile_port_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int AW   = 3,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    wr;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [DW-1:0]      rdata;
   logic               rvalid;
   logic [IDW-1:0]     rid;

   modport master (output req, wr, addr, wdata, input gnt, rdata, rvalid, rid);
   modport slave  (input req, wr, addr, wdata, output gnt, rdata, rvalid, rid);
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing an 8x16 register file between requesters:
// drives the read-mux select and load enables, and returns tagged read data.
module regfile_port_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int AW   = 3,
   parameter int IDW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_port_arbiter_if.slave bus,
   input  logic [DW-1:0]         y,
   output logic [AW-1:0]         s,
   output logic [(2**AW)-1:0]    we,
   output logic [DW-1:0]         din
);
   localparam int NREG = 2**AW;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic [IDW-1:0] idx;
   logic           found;
   logic [NREQ-1:0] elig;
   logic [AW-1:0]  win_addr;
   logic [DW-1:0]  win_wdata;
   logic           rd_pend;
   logic [IDW-1:0] rd_id;

   // The requester granted this cycle is masked so a held request is never
   // granted on two consecutive cycles.
   assign elig = bus.req & ~bus.gnt;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + IDW'(k);
         if (!found && elig[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign win_addr  = bus.addr[win*AW +: AW];
   assign win_wdata = bus.wdata[win*DW +: DW];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.gnt    <= '0;
         s          <= '0;
         we         <= '0;
         din        <= '0;
         bus.rdata  <= '0;
         bus.rvalid <= 1'b0;
         bus.rid    <= '0;
         ptr        <= '0;
         rd_pend    <= 1'b0;
         rd_id      <= '0;
      end else begin
         if (found) begin
            bus.gnt <= NREQ'(1) << win;
            s       <= win_addr;
            if (bus.wr[win]) begin
               we  <= NREG'(1) << win_addr;
               din <= win_wdata;
            end else begin
               we  <= '0;
            end
            ptr     <= win + IDW'(1);
            rd_pend <= ~bus.wr[win];
            rd_id   <= win;
         end else begin
            bus.gnt <= '0;
            we      <= '0;
            rd_pend <= 1'b0;
         end

         // Read capture happens one edge after the grant, once the mux has settled
         // on the new select (and any write from the prior cycle has landed).
         if (rd_pend) begin
            bus.rdata  <= y;
            bus.rid    <= rd_id;
            bus.rvalid <= 1'b1;
         end else begin
            bus.rvalid <= 1'b0;
         end
      end
   end
endmodule
